// File: rtl/connector_box_pkg.sv
// Shared types for the connector box: load FSM state and configuration chain length.
package connector_box_pkg;

    typedef enum logic {
        StIdle,
        StLoad
    } cfg_state_e;

    // One field per output: enable bit plus select bits.
    function automatic int unsigned cfg_bits(input int unsigned inputs,
                                             input int unsigned outputs);
        return outputs * ($clog2(inputs) + 1);
    endfunction

endpackage

// File: rtl/cfg_shift_chain.sv
// Serial configuration chain: shadow shift register, bit counter, load FSM and commit strobe.
module cfg_shift_chain
    import connector_box_pkg::*;
#(
    parameter int unsigned CFG_BITS = 90
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic                in_i,
    output logic                out_o,
    output logic [CFG_BITS-1:0] shadow_o,
    output logic                commit_o,
    output logic                valid_o,
    output logic                err_o
);

    localparam int unsigned CntW = $clog2(CFG_BITS + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(CFG_BITS);

    cfg_state_e          state_q;
    logic [CntW-1:0]     cnt_q;
    logic [CFG_BITS-1:0] shadow_q;
    logic                out_q;
    logic                valid_q;
    logic                err_q;

    // Commit only when the load closes with a full chain's worth of bits.
    assign commit_o = (state_q == StLoad) && !en_i && (cnt_q == CntMax);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            shadow_q <= '0;
            out_q    <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (en_i) begin
                shadow_q <= {in_i, shadow_q[CFG_BITS-1:1]};
                out_q    <= shadow_q[0];
            end
            case (state_q)
                StIdle: begin
                    if (en_i) begin
                        state_q <= StLoad;
                        cnt_q   <= CntW'(1);
                        err_q   <= 1'b0;
                    end
                end
                StLoad: begin
                    if (en_i) begin
                        if (cnt_q != CntMax) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else begin
                        state_q <= StIdle;
                        if (cnt_q == CntMax) begin
                            valid_q <= 1'b1;
                            err_q   <= 1'b0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign out_o    = out_q;
    assign shadow_o = shadow_q;
    assign valid_o  = valid_q;
    assign err_o    = err_q;

endmodule

// File: rtl/cfg_connector_box.sv
// Configurable connector box: serially loaded routing muxes from data_in tracks to data_out.
// Define CFG_CONNECTOR_BOX_REG_OUT_EN to register data_out (one cycle latency).
module cfg_connector_box
    import connector_box_pkg::*;
#(
    parameter int unsigned INPUTS     = 16,
    parameter int unsigned OUTPUTS    = 18,
    parameter int unsigned LOG_INPUTS = $clog2(INPUTS)
) (
    input  logic               config_clk,
    input  logic               config_rst_n,
    input  logic               config_en,
    input  logic               config_in,
    output logic               config_out,
    output logic               cfg_valid,
    output logic               cfg_err,
    input  logic [INPUTS-1:0]  data_in,
    output logic [OUTPUTS-1:0] data_out
);

    localparam int unsigned FieldW   = LOG_INPUTS + 1;
    localparam int unsigned CfgBits  = cfg_bits(INPUTS, OUTPUTS);

    logic [CfgBits-1:0] shadow;
    logic [CfgBits-1:0] active_q;
    logic               commit;
    logic [OUTPUTS-1:0] routed;

    cfg_shift_chain #(
        .CFG_BITS (CfgBits)
    ) u_chain (
        .clk_i    (config_clk),
        .rst_ni   (config_rst_n),
        .en_i     (config_en),
        .in_i     (config_in),
        .out_o    (config_out),
        .shadow_o (shadow),
        .commit_o (commit),
        .valid_o  (cfg_valid),
        .err_o    (cfg_err)
    );

    always_ff @(posedge config_clk or negedge config_rst_n) begin
        if (!config_rst_n) begin
            active_q <= '0;
        end else if (commit) begin
            active_q <= shadow;
        end
    end

    // Selects at or above INPUTS match no track and leave the output low.
    always_comb begin
        routed = '0;
        for (int j = 0; j < int'(OUTPUTS); j++) begin
            if (active_q[j*FieldW + LOG_INPUTS]) begin
                for (int i = 0; i < int'(INPUTS); i++) begin
                    if (active_q[j*FieldW +: LOG_INPUTS] == LOG_INPUTS'(i)) begin
                        routed[j] = data_in[i];
                    end
                end
            end
        end
    end

`ifdef CFG_CONNECTOR_BOX_REG_OUT_EN
    logic [OUTPUTS-1:0] data_out_q;

    always_ff @(posedge config_clk or negedge config_rst_n) begin
        if (!config_rst_n) begin
            data_out_q <= '0;
        end else begin
            data_out_q <= routed;
        end
    end

    assign data_out = data_out_q;
`else
    assign data_out = routed;
`endif

endmodule

// File: tb/tb_cfg_connector_box.sv
// Randomized self-checking bench for cfg_connector_box against a behavioural load/route model.
module tb_cfg_connector_box;

    localparam int NB = 90;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        din_bit = 1'b0;
    logic [15:0] din = '0;
    logic        config_out;
    logic        cfg_valid;
    logic        cfg_err;
    logic [17:0] dout;

    int checks = 0;
    int errors = 0;
    bit chk_on = 0;

    // Model: last NB+1 bits shifted (index 0 = config_out, 1+i = shadow[i]).
    bit          m_hist[$];
    logic [89:0] m_active;
    bit          m_valid;
    bit          m_err;
    bit          m_in_load;
    int          m_len;
    logic [17:0] m_reg;

    always #5 clk = ~clk;

    cfg_connector_box #(
        .INPUTS  (16),
        .OUTPUTS (18)
    ) dut (
        .config_clk   (clk),
        .config_rst_n (rst_n),
        .config_en    (en),
        .config_in    (din_bit),
        .config_out   (config_out),
        .cfg_valid    (cfg_valid),
        .cfg_err      (cfg_err),
        .data_in      (din),
        .data_out     (dout)
    );

    function automatic logic [17:0] route(input logic [89:0] act, input logic [15:0] d);
        logic [17:0] r = '0;
        for (int j = 0; j < 18; j++) begin
            int f = int'((act >> (j * 5)) & 90'h1f);
            if (f >= 16 && (f - 16) < 16) r[j] = d[f-16];
        end
        return r;
    endfunction

    function automatic logic [89:0] model_shadow();
        logic [89:0] s;
        for (int i = 0; i < NB; i++) s[i] = m_hist[1+i];
        return s;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_hist = {};
        for (int i = 0; i <= NB; i++) m_hist.push_back(1'b0);
        m_active = '0;
        m_valid = 0;
        m_err = 0;
        m_in_load = 0;
        m_len = 0;
        m_reg = '0;
    endtask

    task automatic model_edge();
        logic [89:0] sh = model_shadow();
        m_reg = route(m_active, din);
        if (en) begin
            m_hist.push_back(din_bit);
            void'(m_hist.pop_front());
            if (!m_in_load) begin
                m_in_load = 1;
                m_len = 1;
                m_err = 0;
            end else begin
                m_len++;
            end
        end else if (m_in_load) begin
            m_in_load = 0;
            if (m_len >= NB) begin
                m_active = sh;
                m_valid = 1;
                m_err = 0;
            end else begin
                m_err = 1;
            end
        end
    endtask

    task automatic tick(input bit e, input bit b, input logic [15:0] d);
        en = e;
        din_bit = b;
        din = d;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
    endtask

    task automatic shift_vec(input logic [89:0] v, input int n, input logic [15:0] d);
        for (int k = 0; k < n; k++) tick(1'b1, v[k], d);
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("config_out", config_out, m_hist[0]);
            chk("cfg_valid", cfg_valid, m_valid);
            chk("cfg_err", cfg_err, m_err);
`ifdef CFG_CONNECTOR_BOX_REG_OUT_EN
            chk("data_out", dout, m_reg);
`else
            chk("data_out", dout, route(m_active, din));
`endif
        end
    end

    initial begin
        logic [89:0] v1;
        logic [89:0] va;
        logic [89:0] vb;
        logic [89:0] vr;

        model_reset();
        din = 16'hFFFF;
        #3;
        chk("reset_data_out", dout, 18'h0);
        chk("reset_valid", cfg_valid, 1'b0);
        chk("reset_err", cfg_err, 1'b0);
        #9;
        rst_n = 1'b1;
        chk_on = 1;

        // Field0 -> track 1, field1 -> track 3.
        v1 = '0;
        v1[4:0] = 5'b1_0001;
        v1[9:5] = 5'b1_0011;
        shift_vec(v1, NB, 16'h000A);
        tick(1'b0, 1'b0, 16'h000A);
        tick(1'b0, 1'b0, 16'h000A);
        chk("full_load_data_out", dout, 18'h00003);
        chk("full_load_valid", cfg_valid, 1'b1);
        chk("full_load_err", cfg_err, 1'b0);

        for (int k = 0; k < NB; k++) vr[k] = 1'($urandom_range(0, 1));
        shift_vec(vr, 40, 16'h000A);
        tick(1'b0, 1'b0, 16'h000A);
        tick(1'b0, 1'b0, 16'h000A);
        chk("short_load_err", cfg_err, 1'b1);
        chk("short_load_valid", cfg_valid, 1'b1);
        chk("short_load_data_out", dout, 18'h00003);

        // Two boxes' worth: A first, then B; B must be what commits.
        for (int k = 0; k < NB; k++) va[k] = 1'($urandom_range(0, 1));
        vb = '0;
        vb[4:0]   = 5'b1_0001;
        vb[14:10] = 5'b1_0011;
        tick(1'b1, va[0], 16'h000A);
        chk("err_clear_on_start", cfg_err, 1'b0);
        for (int k = 1; k < NB; k++) tick(1'b1, va[k], 16'h000A);
        for (int m = 0; m < NB; m++) begin
            tick(1'b1, vb[m], 16'h000A);
            chk("replay", config_out, va[m]);
        end
        tick(1'b0, 1'b0, 16'h000A);
        tick(1'b0, 1'b0, 16'h000A);
        chk("long_load_data_out", dout, 18'h00005);
        chk("long_load_valid", cfg_valid, 1'b1);
        chk("long_load_err", cfg_err, 1'b0);

        // Reset in the middle of a load.
        shift_vec(v1, 50, 16'hFFFF);
        pulse_reset();
        tick(1'b0, 1'b0, 16'hFFFF);
        tick(1'b0, 1'b0, 16'hFFFF);
        chk("mid_reset_data_out", dout, 18'h0);
        chk("mid_reset_valid", cfg_valid, 1'b0);
        chk("mid_reset_err", cfg_err, 1'b0);

`ifdef CFG_CONNECTOR_BOX_REG_OUT_EN
        shift_vec(v1, NB, 16'h0000);
        tick(1'b0, 1'b0, 16'h0000);
        tick(1'b0, 1'b0, 16'h0000);
        din = 16'h0002;
        #1;
        chk("reg_out_before_edge", dout[0], 1'b0);
        tick(1'b0, 1'b0, 16'h0002);
        chk("reg_out_after_edge", dout[0], 1'b1);
        din = 16'h0000;
        #1;
        chk("reg_out_hold", dout[0], 1'b1);
        tick(1'b0, 1'b0, 16'h0000);
        chk("reg_out_fall", dout[0], 1'b0);
`endif

        // Random loads: short, exact and over-length, with random gaps and resets.
        for (int it = 0; it < 40; it++) begin
            int len;
            int pick = int'($urandom_range(0, 2));
            int rst_at;
            if (pick == 0) len = int'($urandom_range(1, NB - 1));
            else if (pick == 1) len = NB;
            else len = int'($urandom_range(NB + 1, 2 * NB + 20));
            rst_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            for (int k = 0; k < len; k++) begin
                if (k == rst_at) pulse_reset();
                tick(1'b1, 1'($urandom_range(0, 1)), 16'($urandom));
            end
            for (int g = 0; g < int'($urandom_range(1, 4)); g++) begin
                tick(1'b0, 1'($urandom_range(0, 1)), 16'($urandom));
            end
        end

        chk_on = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cfg_connector_box.md
CFG_CONNECTOR_BOX -- requirements
Module: cfg_connector_box

Interface
REQ-001 Parameter INPUTS, default 16: number of routing tracks into data_in.
REQ-002 Parameter OUTPUTS, default 18: number of routed outputs.
REQ-003 Parameter LOG_INPUTS, default $clog2(INPUTS): select field width; field per output is LOG_INPUTS+1 bits (enable MSB, select LSBs); CFG_BITS = OUTPUTS*(LOG_INPUTS+1), 90 at defaults.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset: config_clk and config_rst_n are the only clock and reset.
REQ-005 config_clk  input  1  sole clock, rising edge.
REQ-006 config_rst_n  input  1  asynchronous active-low reset.
REQ-007 config_en  input  1  high = shift one config bit per clock.
REQ-008 config_in  input  1  serial config bit, first-shifted bit lands in chain index 0.
REQ-009 config_out  output  1  bit shifted out of chain index 0, for daisy-chaining.
REQ-010 cfg_valid  output  1  active configuration holds a committed load.
REQ-011 cfg_err  output  1  last load ended short (< CFG_BITS bits).
REQ-012 data_in  input  INPUTS  routing tracks in.
REQ-013 data_out  output  OUTPUTS  routed outputs.

Function
REQ-014 Shadow chain SHALL shift when config_en=1: shadow <= {config_in, shadow[CFG_BITS-1:1]}, config_out <= shadow[0]; field j occupies shadow bits [j*(LOG_INPUTS+1) +: LOG_INPUTS+1].
REQ-015 FSM states SHALL be IDLE and LOAD; IDLE->LOAD on config_en=1 (first bit shifted that edge), LOAD->IDLE on first edge with config_en=0.
REQ-016 Bit counter SHALL clear on IDLE->LOAD, increment per shifted bit, saturate at CFG_BITS.
REQ-017 On LOAD->IDLE with count == CFG_BITS, active <= shadow on that edge, cfg_valid <= 1, cfg_err <= 0.
REQ-018 On LOAD->IDLE with count < CFG_BITS, active SHALL be unchanged, cfg_err <= 1, cfg_valid unchanged.
REQ-019 Loads longer than CFG_BITS (chained boxes) SHALL commit the last CFG_BITS bits received.
REQ-020 cfg_err SHALL clear on IDLE->LOAD; active and data_out SHALL keep previous routing throughout LOAD.
REQ-021 data_out[j] SHALL equal data_in[sel_j] when enable_j=1 and sel_j < INPUTS, else 0.
REQ-022 Without the configuration macro data_out SHALL be combinational from data_in and active (zero latency).
REQ-023 config_en held 0 in IDLE SHALL leave all state unchanged.

Reset
REQ-024 Reset SHALL clear shadow, active, counter, config_out, cfg_valid, cfg_err, FSM to IDLE; data_out = 0.
REQ-025 Reset asserted mid-LOAD SHALL discard the partial load; no commit on release.

Configuration
REQ-026 Macro CFG_CONNECTOR_BOX_REG_OUT_EN defined: data_out SHALL be registered on config_clk, one-cycle latency from data_in/active, reset to 0.
REQ-027 Macro undefined: data_out combinational per REQ-022; no output flops.

Structure
REQ-028 Package connector_box_pkg SHALL hold the FSM state typedef and a function computing CFG_BITS from INPUTS/OUTPUTS.
REQ-029 Sub-module cfg_shift_chain (shadow register, counter, FSM, commit strobe) SHALL be instantiated once; routing muxes stay in cfg_connector_box.

Verification
REQ-030 Reset, data_in=16'hFFFF -> data_out=0, cfg_valid=0, cfg_err=0.
REQ-031 Shift 90 bits with field0=5'b1_0001, field1=5'b1_0011, others 0; data_in=16'h000A -> data_out[0]=1, data_out[1]=1, data_out[17:2]=0, cfg_valid=1.
REQ-032 Shift 40 bits after valid load -> cfg_err=1, cfg_valid=1, data_out unchanged.
REQ-033 Shift 180 bits (two boxes' worth) -> committed routing equals last 90 bits; config_out replays first 90 bits delayed 90 clocks.
REQ-034 Reset pulsed at bit 50 of a load -> data_out=0, cfg_valid=0, no commit after config_en falls.
REQ-035 With CFG_CONNECTOR_BOX_REG_OUT_EN, toggle data_in[1] with field0 selecting 1 -> data_out[0] follows one clock later.
